// File: rtl/pipe_addsub.sv
// Pipelined ripple add/subtract: CHUNK bits of the sum are resolved per stage,
// with the carry registered between stages and a single global advance/stall.

module pipe_addsub_stg #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             v,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s,
    input  logic             ci,
    output logic             v_q,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] s_q,
    output logic             co_q,
    output logic             ovf_q
);
    localparam int LO = K * CHUNK;

    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] s_n;
    logic             cmsb;

    // Carry chain never spans more than this chunk.
    always_comb begin
        part = {1'b0, a[LO +: CHUNK]} + {1'b0, b[LO +: CHUNK]} + {{CHUNK{1'b0}}, ci};
        s_n  = s;
        s_n[LO +: CHUNK] = part[CHUNK-1:0];
        // Carry into the chunk's top bit, recovered from the sum bit.
        cmsb = a[LO+CHUNK-1] ^ b[LO+CHUNK-1] ^ part[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            v_q   <= v;
            a_q   <= a;
            b_q   <= b;
            s_q   <= s_n;
            co_q  <= part[CHUNK];
            ovf_q <= part[CHUNK] ^ cmsb;
        end
    end
endmodule

module pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int NSTG = WIDTH / CHUNK;

    // Index k is the input of stage k; index NSTG is the output register.
    logic [NSTG:0][WIDTH-1:0] a_p, b_p, s_p;
    logic [NSTG:0]            c_p;
    logic [NSTG:0]            vld_pipe;
    logic [NSTG-1:0]          ovf_p;
    logic                     adv;
    logic                     unused_fwd;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign vld_pipe[0] = in_valid;
    assign a_p[0]      = in_a;
    assign b_p[0]      = in_sub ? ~in_b : in_b;
    assign s_p[0]      = '0;
    assign c_p[0]      = in_sub ? ~in_cin : in_cin;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        pipe_addsub_stg #(.WIDTH(WIDTH), .CHUNK(CHUNK), .K(k)) u_stg (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .v     (vld_pipe[k]),
            .a     (a_p[k]),
            .b     (b_p[k]),
            .s     (s_p[k]),
            .ci    (c_p[k]),
            .v_q   (vld_pipe[k+1]),
            .a_q   (a_p[k+1]),
            .b_q   (b_p[k+1]),
            .s_q   (s_p[k+1]),
            .co_q  (c_p[k+1]),
            .ovf_q (ovf_p[k])
        );
    end

    // Last stage's forwarded operands and inner stages' overflow have no consumer.
    assign unused_fwd = ^{a_p[NSTG], b_p[NSTG], ovf_p};

    assign out_valid = vld_pipe[NSTG];
    assign out_sum   = s_p[NSTG];
    assign out_cout  = c_p[NSTG];
    assign out_ovf   = ovf_p[NSTG-1];
endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed vector table, backpressure and reset
// sequences, and a randomized scoreboard run against an arithmetic model.

module tb_pipe_addsub;
    localparam int W    = 32;
    localparam int CH   = 8;
    localparam int NSTG = W / CH;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, in_cin, in_sub;
    logic         out_valid, out_ready, out_cout, out_ovf;
    logic [W-1:0] in_a, in_b, out_sum;

    pipe_addsub #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub;
        logic [W-1:0] sum;
        logic         cout, ovf;
    } vec_t;

    vec_t         tbl[10];
    int           npass = 0, ntot = 0;
    int           nin = 0, nout = 0;
    logic [W+1:0] q[$];
    logic [W+1:0] mexp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // {cout, ovf, sum} from plain integer arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic cin, sub);
        logic [W-1:0] bb;
        logic         c0;
        longint       uv, sv, lim;
        logic         ovf;
        bb  = sub ? ~b : b;
        c0  = sub ? ~cin : cin;
        uv  = longint'(a) + longint'(bb) + longint'(c0);
        sv  = longint'($signed(a)) + longint'($signed(bb)) + longint'(c0);
        lim = 64'sd1 <<< (W-1);
        ovf = (sv >= lim) || (sv < -lim);
        return {uv[W], ovf, uv[W-1:0]};
    endfunction

    always @(posedge clk) begin
        if (rst_n !== 1'b1) q.delete();
        else begin
            if (out_valid && out_ready) begin
                nout++;
                if (q.size() == 0) begin
                    ntot++;
                    $display("FAIL unexpected_out: got sum %h with nothing outstanding", out_sum);
                end else begin
                    mexp = q.pop_front();
                    chk("scoreboard", {out_cout, out_ovf, out_sum}, mexp);
                end
            end
            if (in_valid && in_ready) begin
                nin++;
                q.push_back(model(in_a, in_b, in_cin, in_sub));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        int cyc;
        in_valid = 1'b1; in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub;
        cyc = 0;
        do begin
            tick();
            in_valid = 1'b0;
            cyc++;
        end while (out_valid !== 1'b1 && cyc < 20);
        chk($sformatf("v%0d_latency", i), cyc, NSTG);
        chk($sformatf("v%0d_sum", i), out_sum, v.sum);
        chk($sformatf("v%0d_cout", i), out_cout, v.cout);
        chk($sformatf("v%0d_ovf", i), out_ovf, v.ovf);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ba[8], bb[8];
        logic         bc[8], bs[8];
        int idx, base, o0, n0, cyc, nops;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[3] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
        tbl[5] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[6] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        tbl[7] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
        tbl[8] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 1);

        // First vector is presented in the very first cycle out of reset.
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);
        tick();

        // Back-to-back inputs with out_ready pattern 1,0,0,1,0,0,...
        for (int i = 0; i < 8; i++) begin
            ba[i] = $urandom; bb[i] = $urandom; bc[i] = 1'($urandom); bs[i] = 1'($urandom);
        end
        idx = 0; base = nin; o0 = nout; cyc = 0;
        while (nout - o0 < 8 && cyc < 200) begin
            if (idx < 8) begin
                in_valid = 1'b1; in_a = ba[idx]; in_b = bb[idx]; in_cin = bc[idx]; in_sub = bs[idx];
            end else in_valid = 1'b0;
            out_ready = (cyc % 3 == 0);
            #1;
            chk("bp_in_ready", in_ready, !(out_valid && !out_ready));
            tick();
            idx = nin - base;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_count", nout - o0, 8);

        // Reset with ops in flight: 3 ops flowing, then a stalled full pipe.
        for (int r = 0; r < 2; r++) begin
            nops = (r == 0) ? 3 : 6;
            out_ready = (r == 0);
            repeat (nops) begin
                in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
                in_cin = 1'($urandom); in_sub = 1'($urandom);
                tick();
            end
            in_valid = 1'b0;
            if (r == 1) chk("stall_full", out_valid, 1);
            rst_n = 1'b0;
            tick();
            chk($sformatf("rst%0d_out_valid", r), out_valid, 0);
            chk($sformatf("rst%0d_out_sum", r), out_sum, 0);
            rst_n = 1'b1; out_ready = 1'b1; o0 = nout;
            repeat (12) tick();
            chk($sformatf("rst%0d_flushed", r), nout - o0, 0);
        end

        // Random regression with random bubbles and stalls.
        n0 = nin; cyc = 0;
        while (nin - n0 < 2000 && cyc < 20000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: in_a = '1;
                1: in_a = 32'h8000_0000;
                2: in_a = 32'h7FFF_FFFF;
                default: in_a = $urandom;
            endcase
            in_b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            in_cin = 1'($urandom); in_sub = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("rand_transfers", (nin - n0) >= 2000, 1);
        chk("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
